poly_mult_result_packer: RTL and testbench

//  Downstream readout stage for the sparse polynomial multiplier. On completion it walks the
//  32-bit result RAM through the multiplier's result port. It masks bits above degree N-1 and

---
 rtl/poly_mult_pkg.sv | 25 ++
 rtl/poly_mult_result_packer.sv | 97 +++++++++
 tb/tb_poly_mult_result_packer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/poly_mult_pkg.sv
// Shared constants for the sparse polynomial multiplier readout path.
// Holds geometry, the last-word mask and the packer FSM encoding.
package poly_mult_pkg;
  localparam int N          = 17_669;
  localparam int RAMWIDTH   = 32;
  localparam int LANES      = 4;
  localparam int BEAT_W     = LANES * RAMWIDTH;
  localparam int NUM_WORDS  = (N + RAMWIDTH - 1) / RAMWIDTH;
  localparam int NUM_BEATS  = (NUM_WORDS + LANES - 1) / LANES;
  localparam int ADDR_WIDTH = 10;
  localparam int BEAT_CNT_W = $clog2(NUM_BEATS);
  localparam int LAST_BITS  = N % RAMWIDTH;

  // Bits of the final word above degree N-1 are garbage and get cleared.
  localparam logic [RAMWIDTH-1:0] LAST_MASK = (LAST_BITS == 0) ? {RAMWIDTH{1'b1}}
                                            : RAMWIDTH'((64'd1 << LAST_BITS) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(NUM_BEATS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
endpackage

// File: rtl/poly_mult_result_packer.sv
// Walks the multiplier result RAM after completion and packs four masked words
// per 128-bit beat onto a valid/ready stream.
module poly_mult_result_packer
  import poly_mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  mult_valid_i,
  output logic [ADDR_WIDTH-1:0] addr_result_o,
  output logic                  rd_dout_o,
  input  logic [RAMWIDTH-1:0]   dout_i,
  output logic [BEAT_W-1:0]     beat_o,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic                  beat_last_o,
  output logic                  busy_o
);

  logic [2:0]                       state;
  logic [ADDR_WIDTH-1:0]            word_cnt;
  logic [BEAT_CNT_W-1:0]            beat_cnt;
  logic [LANES-1:0][RAMWIDTH-1:0]   lanes, lanes_nxt;
  logic [RAMWIDTH-1:0]              cap_word;
  logic                             last_word, beat_full;

  // Address is the word counter itself, so it stays put through OUT stalls.
  assign addr_result_o = word_cnt;
  assign rd_dout_o     = (state == S_ISSUE) || (state == S_CAPT) || (state == S_OUT);
  assign busy_o        = (state != S_IDLE);

  always_comb begin
    last_word = (word_cnt == LAST_WORD);
    beat_full = (word_cnt[1:0] == 2'd3) || last_word;
    cap_word  = last_word ? (dout_i & LAST_MASK) : dout_i;
    lanes_nxt = lanes;
    for (int j = 0; j < LANES; j++)
      if (word_cnt[1:0] == 2'(j)) lanes_nxt[j] = cap_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      word_cnt     <= '0;
      beat_cnt     <= '0;
      lanes        <= '0;
      beat_o       <= '0;
      beat_valid_o <= 1'b0;
      beat_last_o  <= 1'b0;
    end else if (clear_i) begin
      state        <= S_IDLE;
      word_cnt     <= '0;
      beat_cnt     <= '0;
      lanes        <= '0;
      beat_o       <= '0;
      beat_valid_o <= 1'b0;
      beat_last_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mult_valid_i) begin
            word_cnt <= '0;
            beat_cnt <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_CAPT;
        S_CAPT: begin
          lanes <= lanes_nxt;
          if (beat_full) begin
            beat_o       <= lanes_nxt;
            beat_valid_o <= 1'b1;
            beat_last_o  <= (beat_cnt == LAST_BEAT);
            state        <= S_OUT;
          end else begin
            word_cnt <= word_cnt + 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_OUT: begin
          if (beat_ready_i) begin
            lanes        <= '0;
            word_cnt     <= word_cnt + 1'b1;
            beat_cnt     <= beat_cnt + 1'b1;
            beat_valid_o <= 1'b0;
            beat_last_o  <= 1'b0;
            state        <= beat_last_o ? S_DONE : S_ISSUE;
          end
        end
        // Hold here until the done level drops so a stuck flag cannot retrigger.
        S_DONE: if (!mult_valid_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_mult_result_packer.sv
// Randomized self-checking bench for poly_mult_result_packer against a
// word-level model of the expected beat stream.
module tb_poly_mult_result_packer;
  localparam int N   = 17669;
  localparam int W   = 32;
  localparam int NW  = (N + W - 1) / W;
  localparam int NB  = (NW + 3) / 4;
  localparam int REM = N % W;

  logic         clk = 1'b0, rst_n = 1'b0, clear_i = 1'b0, mult_valid_i = 1'b0, beat_ready_i = 1'b0;
  logic [9:0]   addr_result_o;
  logic         rd_dout_o, beat_valid_o, beat_last_o, busy_o;
  logic [31:0]  dout_i;
  logic [127:0] beat_o;

  logic [31:0]  mem [0:1023];
  int           tests = 0, fails = 0;
  logic [127:0] got[$];
  bit           got_last[$];
  int           unstable, addr_bad, stalls;
  bit           timed_out;

  always #5 clk = ~clk;
  // Result RAM: data appears one cycle after the address.
  always @(posedge clk) dout_i <= mem[addr_result_o];

  poly_mult_result_packer dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .mult_valid_i(mult_valid_i),
    .addr_result_o(addr_result_o), .rd_dout_o(rd_dout_o), .dout_i(dout_i),
    .beat_o(beat_o), .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
    .beat_last_o(beat_last_o), .busy_o(busy_o)
  );

  task automatic fill(input int mode);
    for (int k = 0; k < 1024; k++)
      mem[k] = (mode == 0) ? 32'(k + 1) : (mode == 1) ? 32'hFFFF_FFFF : $urandom;
  endtask

  function automatic logic [127:0] exp_beat(input int b);
    logic [127:0] r = '0;
    logic [31:0]  w;
    for (int j = 0; j < 4; j++) begin
      int k = 4 * b + j;
      w = (k < NW) ? mem[k] : 32'd0;
      if (k == NW - 1 && REM != 0) w = w & ((32'd1 << REM) - 32'd1);
      r[32*j +: 32] = w;
    end
    return r;
  endfunction

  task automatic start(input bit hold);
    @(negedge clk); mult_valid_i = 1'b1;
    if (!hold) begin @(negedge clk); mult_valid_i = 1'b0; end
  endtask

  // Collects beats; mode 0 ready=1, 1 random ready, 2 stall 7 cycles at beat
  // 'special', 3 assert clear_i when beat 'special' is presented.
  task automatic drain(input int mode, input int special);
    bit pw = 0, pl = 0;
    logic [127:0] pb = '0;
    logic [9:0] pa = '0;
    int sc = 0;
    got.delete(); got_last.delete();
    unstable = 0; addr_bad = 0; stalls = 0; timed_out = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (pw && (!beat_valid_o || beat_o !== pb || beat_last_o !== pl || addr_result_o !== pa))
        unstable++;
      case (mode)
        1: beat_ready_i = 1'($urandom_range(0, 1));
        2: beat_ready_i = !(beat_valid_o && got.size() == special && sc < 7);
        default: beat_ready_i = 1'b1;
      endcase
      if (mode == 2 && !beat_ready_i) begin
        sc++; stalls++;
        if (addr_result_o !== 10'(4 * special + 3)) addr_bad++;
      end
      if (mode == 3 && beat_valid_o && got.size() == special) begin
        beat_ready_i = 1'b0; clear_i = 1'b1; timed_out = 0; return;
      end
      pw = beat_valid_o && !beat_ready_i; pb = beat_o; pl = beat_last_o; pa = addr_result_o;
      if (beat_valid_o && beat_ready_i) begin
        got.push_back(beat_o); got_last.push_back(beat_last_o);
        if (beat_last_o) begin @(negedge clk); timed_out = 0; return; end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if ({busy_o, beat_valid_o, beat_last_o, rd_dout_o} !== 4'b0) begin
      fails++; $display("FAIL reset_flags got %b want 0000", {busy_o, beat_valid_o, beat_last_o, rd_dout_o}); end
    tests++; if (addr_result_o !== 10'd0 || beat_o !== 128'd0) begin
      fails++; $display("FAIL reset_data addr %0d beat %h want 0", addr_result_o, beat_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_incrementing();
    int lat = 0;
    fill(0);
    @(negedge clk); beat_ready_i = 1'b1; mult_valid_i = 1'b1;
    do begin @(posedge clk); #1; lat++; mult_valid_i = 1'b0; end while (!beat_valid_o && lat < 40);
    tests++; if (lat !== 9) begin fails++; $display("FAIL first_beat_latency got %0d want 9", lat); end
    drain(0, 0);
    tests++; if (timed_out || got.size() != NB) begin
      fails++; $display("FAIL inc_beat_count got %0d want %0d timeout %0d", got.size(), NB, timed_out); end
    if (got.size() == NB) begin
      tests++; if (got[0] !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
        fails++; $display("FAIL inc_beat0 got %h want 4/3/2/1", got[0]); end
      tests++; if (got[NB-1] !== 128'h9 || got_last[NB-1] !== 1'b1) begin
        fails++; $display("FAIL inc_last got %h last %0d want 9 last 1", got[NB-1], got_last[NB-1]); end
      for (int b = 0; b < NB; b++) begin
        tests++; if (got[b] !== exp_beat(b) || got_last[b] !== (b == NB - 1)) begin
          fails++; $display("FAIL inc_beat[%0d] got %h/%0d want %h", b, got[b], got_last[b], exp_beat(b)); end
      end
    end
  endtask

  task automatic test_all_ones();
    fill(1);
    start(0); drain(0, 0);
    tests++; if (timed_out || got.size() != NB) begin
      fails++; $display("FAIL ones_count got %0d want %0d", got.size(), NB); end
    if (got.size() == NB) begin
      tests++; if (got[NB-1] !== 128'h1F) begin fails++; $display("FAIL ones_last got %h want 1f", got[NB-1]); end
      for (int b = 0; b < NB - 1; b++) begin
        tests++; if (got[b] !== {128{1'b1}}) begin fails++; $display("FAIL ones_beat[%0d] got %h want all ones", b, got[b]); end
      end
    end
  endtask

  task automatic test_stall();
    fill(2);
    start(0); drain(2, 5);
    tests++; if (stalls !== 7 || unstable !== 0 || addr_bad !== 0) begin
      fails++; $display("FAIL stall stalls %0d unstable %0d addr_bad %0d want 7/0/0", stalls, unstable, addr_bad); end
    tests++; if (timed_out || got.size() != NB) begin
      fails++; $display("FAIL stall_count got %0d want %0d", got.size(), NB); end
    for (int b = 0; b < got.size() && b < NB; b++) begin
      tests++; if (got[b] !== exp_beat(b)) begin fails++; $display("FAIL stall_beat[%0d] got %h want %h", b, got[b], exp_beat(b)); end
    end
  endtask

  task automatic test_clear();
    fill(2);
    start(0); drain(3, 40);
    tests++; if (timed_out) begin fails++; $display("FAIL clear_reach beat 40 not seen, got %0d beats", got.size()); end
    @(negedge clk); clear_i = 1'b0;
    tests++; if ({busy_o, beat_valid_o, rd_dout_o} !== 3'b000) begin
      fails++; $display("FAIL clear_flags got %b want 000", {busy_o, beat_valid_o, rd_dout_o}); end
    beat_ready_i = 1'b1; mult_valid_i = 1'b1;
    @(posedge clk); #1; mult_valid_i = 1'b0;
    tests++; if (rd_dout_o !== 1'b1 || addr_result_o !== 10'd0) begin
      fails++; $display("FAIL clear_restart rd %0d addr %0d want 1/0", rd_dout_o, addr_result_o); end
    drain(0, 0);
    tests++; if (timed_out || got.size() != NB) begin fails++; $display("FAIL clear_count got %0d want %0d", got.size(), NB); end
    for (int b = 0; b < got.size() && b < NB; b++) begin
      tests++; if (got[b] !== exp_beat(b)) begin fails++; $display("FAIL clear_beat[%0d] got %h want %h", b, got[b], exp_beat(b)); end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    fill(0);
    beat_ready_i = 1'b1;
    start(0);
    while (!beat_valid_o && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    tests++; if ({busy_o, beat_valid_o, beat_last_o, rd_dout_o} !== 4'b0 || beat_o !== 128'd0 || addr_result_o !== 10'd0) begin
      fails++; $display("FAIL async_reset flags %b beat %h addr %0d want 0", {busy_o, beat_valid_o, beat_last_o, rd_dout_o}, beat_o, addr_result_o); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (busy_o !== 1'b0 || beat_valid_o !== 1'b0) begin
      fails++; $display("FAIL async_idle busy %0d valid %0d want 0/0", busy_o, beat_valid_o); end
    start(0); drain(0, 0);
    tests++; if (timed_out || got.size() != NB || got[0] !== exp_beat(0)) begin
      fails++; $display("FAIL async_rerun count %0d want %0d", got.size(), NB); end
  endtask

  task automatic test_hold_done();
    int bad = 0;
    fill(2);
    start(1); drain(0, 0);
    repeat (20) begin
      @(negedge clk);
      if (!busy_o || beat_valid_o || rd_dout_o) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL hold_done bad cycles got %0d want 0", bad); end
    mult_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL hold_release busy got %0d want 0", busy_o); end
    start(0); drain(0, 0);
    tests++; if (timed_out || got.size() != NB) begin fails++; $display("FAIL hold_rerun_count got %0d want %0d", got.size(), NB); end
    for (int b = 0; b < got.size() && b < NB; b++) begin
      tests++; if (got[b] !== exp_beat(b)) begin fails++; $display("FAIL hold_beat[%0d] got %h want %h", b, got[b], exp_beat(b)); end
    end
  endtask

  task automatic test_random_ready();
    fill(2);
    start(0); drain(1, 0);
    tests++; if (timed_out || got.size() != NB || unstable !== 0) begin
      fails++; $display("FAIL rand_count got %0d want %0d unstable %0d", got.size(), NB, unstable); end
    for (int b = 0; b < got.size() && b < NB; b++) begin
      tests++; if (got[b] !== exp_beat(b) || got_last[b] !== (b == NB - 1)) begin
        fails++; $display("FAIL rand_beat[%0d] got %h want %h", b, got[b], exp_beat(b)); end
    end
  endtask

  initial begin
    fill(0);
    test_reset();
    test_incrementing();
    test_all_ones();
    test_stall();
    test_clear();
    test_async_reset();
    test_hold_done();
    test_random_ready();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
